softoserdes_gearbox: RTL



---
 rtl/softoserdes_gearbox.sv | 87 ++++++++
 1 files changed

// File: rtl/softoserdes_gearbox.sv
// softoserdes_gearbox: soft DDR/SDR serializer with holding register, idle-word underrun accounting
// and optional training-pattern override (enabled by defining SOFTSER_TRAIN_EN).
module softoserdes_gearbox #(
   parameter int LANES = 2,
   parameter int WIDTH = 10,
   parameter int DDR = 1,
   parameter int LSB_FIRST = 1,
   parameter logic [WIDTH-1:0] IDLE_WORD = '0,
   parameter logic [WIDTH-1:0] TRAIN_WORD = 10'h0F8
) (
   input  logic                   clk_ser,
   input  logic                   rst_n,
   input  logic [LANES*WIDTH-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   train,
   output logic [LANES-1:0]       out_rise,
   output logic [LANES-1:0]       out_fall,
   output logic                   word_start,
   output logic                   underrun,
   output logic [7:0]             underrun_cnt
);
   localparam int BPC = (DDR != 0) ? 2 : 1;
   localparam int N = WIDTH / BPC;
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [SW-1:0]                   slot;
   logic [LANES*WIDTH-1:0]          hold;
   logic                            hold_full;
   logic [LANES-1:0][WIDTH-1:0]     sh;
   logic [LANES-1:0][WIDTH-1:0]     nxt;
   logic                            boundary;
   logic                            train_sel;
   logic                            load_hold;
   logic                            load_idle;
   logic                            accept;

`ifdef SOFTSER_TRAIN_EN
   assign train_sel = train;
`else
   logic unused_train;
   assign unused_train = train;
   assign train_sel = 1'b0;
`endif

   assign boundary = (slot == SW'(N - 1));
   assign load_hold = boundary && hold_full && !train_sel;
   assign load_idle = boundary && !hold_full && !train_sel;
   assign in_ready = !hold_full || load_hold;
   assign accept = in_valid && in_ready;

   // next word per lane at a slot boundary, and output bit taps from the shift registers
   always_comb begin
      nxt = '0;
      out_rise = '0;
      out_fall = '0;
      for (int k = 0; k < LANES; k++) begin
         nxt[k] = train_sel ? TRAIN_WORD : hold_full ? hold[k*WIDTH +: WIDTH] : IDLE_WORD;
         out_rise[k] = (LSB_FIRST != 0) ? sh[k][0] : sh[k][WIDTH-1];
         out_fall[k] = (DDR == 0) ? out_rise[k] : (LSB_FIRST != 0) ? sh[k][1] : sh[k][WIDTH-2];
      end
   end

   // slot counter, holding register, per-lane shift registers and underrun accounting
   always_ff @(posedge clk_ser or negedge rst_n) begin
      if (!rst_n) begin
         slot <= SW'(N - 1);
         hold <= '0;
         hold_full <= 1'b0;
         sh <= '0;
         word_start <= 1'b0;
         underrun <= 1'b0;
         underrun_cnt <= 8'd0;
      end else begin
         slot <= boundary ? '0 : slot + SW'(1);
         word_start <= boundary;
         underrun <= load_idle;
         if (load_idle && underrun_cnt != 8'hFF)
            underrun_cnt <= underrun_cnt + 8'd1;
         if (accept)
            hold <= in_data;
         hold_full <= accept || (hold_full && !load_hold);
         for (int k = 0; k < LANES; k++)
            sh[k] <= boundary ? nxt[k] : (LSB_FIRST != 0) ? sh[k] >> BPC : sh[k] << BPC;
      end
   end
endmodule
